sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter ROWBITS, default 4: stored row-address bits, RA[ROWBITS-1:0].
REQ-002 Parameter COLBITS, default 8: stored column-address bits, RA[COLBITS-1:0].
REQ-003 C14M  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 CKE  in  1  clock enable; 0 = command ignored.
REQ-006 nCS, nRAS, nCAS, nRWE  in  1 each  SDRAM command strobes, active-low.
REQ-007 BA  in  2  bank address.
REQ-008 RA  in  12  row/column/mode address; RA[10] = auto-precharge/all flag.
REQ-009 DQML, DQMH  in  1 each  byte masks, lane 0 = DQ[7:0], lane 1 = DQ[15:8].
REQ-010 DQin  in  16  write data from initiator.
REQ-011 DQout  out  16  read data.
REQ-012 DQOE  out  2  per-lane read-drive enable.
REQ-013 ModeReg  out  12  last MRS value.
REQ-014 Ready  out  1  high once an MRS is accepted.
REQ-015 RefCount  out  16  saturating count of accepted REF commands.
REQ-016 ProtoErr  out  1  sticky protocol-violation flag.
REQ-017 ErrCode  out  3  code of the first violation.

Function
REQ-018 Decode the command only when CKE=1 and nCS=0. {nRAS,nCAS,nRWE} decodes as: 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 111 NOP, 110 BST.
REQ-019 Storage SHALL be 4*2^ROWBITS*2^COLBITS x16, indexed {BA, row, col}; upper RA bits are ignored.
REQ-020 Per-bank state SHALL be Active flag plus latched row; ACT on an idle bank sets Active and latches RA.
REQ-021 ACT on an active bank: overwrite the row and raise error 1.
REQ-022 READ/WRITE on an idle bank: ignore the command, no data, raise error 2.
REQ-023 READ/WRITE with RA[10]=1 clears the bank's Active flag on the same edge (auto-precharge).
REQ-024 PRE: RA[10]=1 idles all banks; RA[10]=0 idles bank BA; PRE on an idle bank is legal.
REQ-025 REF requires all banks idle, else raise error 3 and do not count; otherwise RefCount increments, saturating at FFFF.
REQ-026 MRS requires all banks idle, else raise error 3 and ignore.
  - When accepted: ModeReg<=RA and Ready<=1.
  - If RA[2:0]!=0 (burst requested), raise error 4; still latch.
REQ-027 CAS latency CL = ModeReg[6:4] when that field is 2 or 3. Any other value, or no MRS yet: CL=2; error 5 is raised on a READ issued while CL is defaulted after an MRS.
REQ-028 WRITE sampled at edge n writes DQin per lane where the lane's DQM=0 at edge n; masked lanes are unchanged.
REQ-029 READ sampled at edge n:
  - DQout = stored word, driven after edge n+CL-1 and held until after edge n+CL, so the initiator samples at edge n+CL.
  - DQOE[lane] = 1 for that one cycle only if the lane's DQM was 0 at edge n+CL-2 (read mask latency 2).
REQ-030 WRITE at edge n followed by READ of the same address at edge n+1 SHALL return the new data.
REQ-031 The read pipeline SHALL be CL stages deep, one READ per cycle; back-to-back READs give contiguous DQOE cycles.
REQ-032 A pending read SHALL still complete if CKE drops.
REQ-033 BST: no effect; raise error 6.
REQ-034 ProtoErr sets on the first error; ErrCode latches only while ProtoErr=0.

Reset
REQ-035 While RST=1, asynchronously:
  - all banks idle; read pipeline flushed;
  - DQOE=00, DQout=0000;
  - ModeReg=000, Ready=0, RefCount=0, ProtoErr=0, ErrCode=0.
REQ-036 Memory contents are not reset.
REQ-037 RST asserted mid-read SHALL cancel the pending DQOE.

Verification
REQ-038 Reset, PRE all, 16x REF, MRS RA=0x220 -> RefCount=16, ModeReg=0x220, Ready=1, ProtoErr=0.
REQ-039 ACT bank0 row 5; WRITE col 0x3C, RA[10]=1, DQin=0xA55A, DQML=0, DQMH=1; ACT; READ, both DQM 0 -> lane0 DQOE=1 exactly 2 edges after READ, DQout[7:0]=0x5A; bank idle after each auto-precharge.
REQ-040 MRS CL=3; READ at edge n -> DQOE high only between edges n+2 and n+3; DQMH=1 at edge n+1 -> DQOE=01.
REQ-041 READ to idle bank -> no DQOE, ProtoErr=1, ErrCode=2; later ACT on active bank leaves ErrCode=2.
REQ-042 REF with bank 2 active -> RefCount unchanged, ErrCode=3; RST mid-read -> DQOE=00 immediately.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural SDRAM target: decodes SDRAM commands, stores banked x16 data behind a
// CAS-latency read pipeline and records the first protocol violation it sees.
module sdram_responder #(
    parameter int unsigned ROWBITS = 4,
    parameter int unsigned COLBITS = 8
) (
    input  logic        C14M,
    input  logic        RST,
    input  logic        CKE,
    input  logic        nCS,
    input  logic        nRAS,
    input  logic        nCAS,
    input  logic        nRWE,
    input  logic [1:0]  BA,
    input  logic [11:0] RA,
    input  logic        DQML,
    input  logic        DQMH,
    input  logic [15:0] DQin,
    output logic [15:0] DQout,
    output logic [1:0]  DQOE,
    output logic [11:0] ModeReg,
    output logic        Ready,
    output logic [15:0] RefCount,
    output logic        ProtoErr,
    output logic [2:0]  ErrCode
);
    localparam int unsigned AW    = ROWBITS + COLBITS + 2;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        CmdMrs   = 3'b000,
        CmdRef   = 3'b001,
        CmdPre   = 3'b010,
        CmdAct   = 3'b011,
        CmdWrite = 3'b100,
        CmdRead  = 3'b101,
        CmdBst   = 3'b110,
        CmdNop   = 3'b111
    } cmd_e;

    logic [15:0]        r_mem [DEPTH];
    logic [3:0]         r_active;
    logic [ROWBITS-1:0] r_row [4];
    logic               r_p2_vld;
    logic [15:0]        r_p2_data;
    logic               r_p1_vld;
    logic [15:0]        r_p1_data;
    logic [1:0]         r_p1_mask;

    cmd_e               w_cmd;
    logic               w_act, w_rd, w_wr, w_pre, w_ref, w_mrs, w_bst;
    logic               w_bank_active, w_all_idle;
    logic               w_rd_ok, w_wr_ok;
    logic               w_cl_ok, w_cl3;
    logic [AW-1:0]      w_addr;
    logic [15:0]        w_rd_data;
    logic               w_err;
    logic [2:0]         w_err_code;

    assign w_cmd         = cmd_e'({nRAS, nCAS, nRWE});
    assign w_bank_active = r_active[BA];
    assign w_all_idle    = (r_active == 4'b0000);
    assign w_rd_ok       = w_rd && w_bank_active;
    assign w_wr_ok       = w_wr && w_bank_active;
    assign w_cl_ok       = (ModeReg[6:4] == 3'd2) || (ModeReg[6:4] == 3'd3);
    assign w_cl3         = (ModeReg[6:4] == 3'd3);
    assign w_addr        = {BA, r_row[BA], RA[COLBITS-1:0]};
    assign w_rd_data     = r_mem[w_addr];

    always_comb begin
        w_act = 1'b0;
        w_rd  = 1'b0;
        w_wr  = 1'b0;
        w_pre = 1'b0;
        w_ref = 1'b0;
        w_mrs = 1'b0;
        w_bst = 1'b0;
        if (CKE && !nCS) begin
            case (w_cmd)
                CmdAct:   w_act = 1'b1;
                CmdRead:  w_rd  = 1'b1;
                CmdWrite: w_wr  = 1'b1;
                CmdPre:   w_pre = 1'b1;
                CmdRef:   w_ref = 1'b1;
                CmdMrs:   w_mrs = 1'b1;
                CmdBst:   w_bst = 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_err      = 1'b1;
        w_err_code = 3'd0;
        if (w_act && w_bank_active)                    w_err_code = 3'd1;
        else if ((w_rd || w_wr) && !w_bank_active)     w_err_code = 3'd2;
        else if ((w_ref || w_mrs) && !w_all_idle)      w_err_code = 3'd3;
        else if (w_mrs && (RA[2:0] != 3'd0))           w_err_code = 3'd4;
        else if (w_rd && Ready && !w_cl_ok)            w_err_code = 3'd5;
        else if (w_bst)                                w_err_code = 3'd6;
        else                                           w_err      = 1'b0;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge C14M) begin
        if (w_wr_ok && !DQML) r_mem[w_addr][7:0]  <= DQin[7:0];
        if (w_wr_ok && !DQMH) r_mem[w_addr][15:8] <= DQin[15:8];
    end

    always_ff @(posedge C14M or posedge RST) begin
        if (RST) begin
            r_active <= 4'b0000;
            for (int i = 0; i < 4; i++) r_row[i] <= '0;
            ModeReg  <= 12'h000;
            Ready    <= 1'b0;
            RefCount <= 16'h0000;
            ProtoErr <= 1'b0;
            ErrCode  <= 3'd0;
        end else begin
            if (w_act) begin
                r_active[BA] <= 1'b1;
                r_row[BA]    <= RA[ROWBITS-1:0];
            end
            if ((w_rd_ok || w_wr_ok) && RA[10]) r_active[BA] <= 1'b0;
            if (w_pre) begin
                if (RA[10]) r_active     <= 4'b0000;
                else        r_active[BA] <= 1'b0;
            end
            if (w_ref && w_all_idle && (RefCount != 16'hFFFF)) RefCount <= RefCount + 16'd1;
            if (w_mrs && w_all_idle) begin
                ModeReg <= RA;
                Ready   <= 1'b1;
            end
            if (w_err && !ProtoErr) begin
                ProtoErr <= 1'b1;
                ErrCode  <= w_err_code;
            end
        end
    end

    // CL3 reads enter one stage earlier; lane masks are captured when stage 1 loads,
    // which is always the edge CL-2 after the READ.
    always_ff @(posedge C14M or posedge RST) begin
        if (RST) begin
            r_p2_vld  <= 1'b0;
            r_p2_data <= 16'h0000;
            r_p1_vld  <= 1'b0;
            r_p1_data <= 16'h0000;
            r_p1_mask <= 2'b00;
            DQOE      <= 2'b00;
            DQout     <= 16'h0000;
        end else begin
            r_p2_vld  <= w_rd_ok && w_cl3;
            r_p2_data <= w_rd_data;
            if (w_rd_ok && !w_cl3) begin
                r_p1_vld  <= 1'b1;
                r_p1_data <= w_rd_data;
            end else begin
                r_p1_vld  <= r_p2_vld;
                r_p1_data <= r_p2_data;
            end
            r_p1_mask <= ~{DQMH, DQML};
            DQOE      <= r_p1_vld ? r_p1_mask : 2'b00;
            if (r_p1_vld) DQout <= r_p1_data;
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed vector table, hand-written
// latency/reset sequences and a randomized run against a behavioural model.
module tb_sdram_responder;
    logic        C14M = 1'b0;
    logic        RST, CKE, nCS, nRAS, nCAS, nRWE, DQML, DQMH;
    logic [1:0]  BA;
    logic [11:0] RA;
    logic [15:0] DQin;
    logic [15:0] DQout;
    logic [1:0]  DQOE;
    logic [11:0] ModeReg;
    logic        Ready;
    logic [15:0] RefCount;
    logic        ProtoErr;
    logic [2:0]  ErrCode;

    localparam logic [2:0] MRS = 3'd0, REF = 3'd1, PRE = 3'd2, ACT = 3'd3;
    localparam logic [2:0] WR = 3'd4, RD = 3'd5, BST = 3'd6, NOP = 3'd7;

    always #5 C14M = ~C14M;

    sdram_responder #(.ROWBITS(4), .COLBITS(8)) dut (
        .C14M(C14M), .RST(RST), .CKE(CKE), .nCS(nCS), .nRAS(nRAS), .nCAS(nCAS),
        .nRWE(nRWE), .BA(BA), .RA(RA), .DQML(DQML), .DQMH(DQMH), .DQin(DQin),
        .DQout(DQout), .DQOE(DQOE), .ModeReg(ModeReg), .Ready(Ready),
        .RefCount(RefCount), .ProtoErr(ProtoErr), .ErrCode(ErrCode)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          e = 0;
    logic [1:0]  m_hist [int];
    bit          m_act [4];
    int          m_row [4];
    logic [15:0] m_mem [int];
    logic [1:0]  m_kn [int];
    logic [11:0] m_mode;
    bit          m_ready, m_perr;
    int          m_ref, m_ecode;
    logic [15:0] p_data [int];
    logic [1:0]  p_kn [int];
    int          p_medge [int];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_row[i] = 0; end
        m_mode = 12'h000; m_ready = 0; m_ref = 0; m_perr = 0; m_ecode = 0;
        p_data.delete(); p_kn.delete(); p_medge.delete();
    endtask

    task automatic raise(input int code);
        if (!m_perr) begin m_perr = 1; m_ecode = code; end
    endtask

    task automatic model_step();
        int b, a, cl, due;
        bit idle, cl_ok;
        logic [15:0] w, mask16;
        logic [1:0] k, exp_oe, ml;
        e++;
        m_hist[e] = {DQMH, DQML};
        if (CKE && !nCS) begin
            b     = int'(BA);
            idle  = !(m_act[0] || m_act[1] || m_act[2] || m_act[3]);
            cl_ok = (m_mode[6:4] == 3'd2) || (m_mode[6:4] == 3'd3);
            cl    = cl_ok ? int'(m_mode[6:4]) : 2;
            case ({nRAS, nCAS, nRWE})
                ACT: begin
                    if (m_act[b]) raise(1);
                    m_act[b] = 1; m_row[b] = int'(RA[3:0]);
                end
                RD, WR: begin
                    if (!m_act[b]) raise(2);
                    else begin
                        a = b * 4096 + m_row[b] * 256 + int'(RA[7:0]);
                        if ({nRAS, nCAS, nRWE} == RD) begin
                            if (m_ready && !cl_ok) raise(5);
                            due = e + cl - 1;
                            p_data[due]  = m_mem.exists(a) ? m_mem[a] : 16'h0;
                            p_kn[due]    = m_kn.exists(a) ? m_kn[a] : 2'b00;
                            p_medge[due] = e + cl - 2;
                        end else begin
                            w = m_mem.exists(a) ? m_mem[a] : 16'h0;
                            k = m_kn.exists(a) ? m_kn[a] : 2'b00;
                            if (!DQML) begin w[7:0]  = DQin[7:0];  k[0] = 1'b1; end
                            if (!DQMH) begin w[15:8] = DQin[15:8]; k[1] = 1'b1; end
                            m_mem[a] = w; m_kn[a] = k;
                        end
                        if (RA[10]) m_act[b] = 0;
                    end
                end
                PRE: begin
                    if (RA[10]) for (int i = 0; i < 4; i++) m_act[i] = 0;
                    else m_act[b] = 0;
                end
                REF: begin
                    if (!idle) raise(3);
                    else if (m_ref < 65535) m_ref++;
                end
                MRS: begin
                    if (!idle) raise(3);
                    else begin
                        if (RA[2:0] != 3'd0) raise(4);
                        m_mode = RA; m_ready = 1;
                    end
                end
                BST: raise(6);
                default: ;
            endcase
        end
        exp_oe = 2'b00;
        if (p_data.exists(e)) begin
            exp_oe = ~m_hist[p_medge[e]];
            ml     = exp_oe & p_kn[e];
            mask16 = {{8{ml[1]}}, {8{ml[0]}}};
            if (ml != 2'b00) check("model.DQout", DQout & mask16, p_data[e] & mask16);
            p_data.delete(e); p_kn.delete(e); p_medge.delete(e);
        end
        check("model.DQOE", DQOE, exp_oe);
        check("model.ProtoErr", ProtoErr, m_perr);
        check("model.ErrCode", ErrCode, m_ecode);
        check("model.RefCount", RefCount, m_ref);
        check("model.Ready", Ready, m_ready);
        check("model.ModeReg", ModeReg, m_mode);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                         input logic [1:0] m, input logic [15:0] d,
                         input logic cke, input logic ncs);
        CKE = cke; nCS = ncs; {nRAS, nCAS, nRWE} = c;
        BA = b; RA = a; {DQMH, DQML} = m; DQin = d;
        @(posedge C14M);
        #1;
        model_step();
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                       input logic [1:0] m, input logic [15:0] d);
        drive(c, b, a, m, d, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check("rst.DQOE", DQOE, 2'b00);
        check("rst.DQout", DQout, 16'h0000);
        check("rst.ModeReg", ModeReg, 12'h000);
        check("rst.Ready", Ready, 1'b0);
        check("rst.RefCount", RefCount, 16'h0000);
        check("rst.ProtoErr", ProtoErr, 1'b0);
        check("rst.ErrCode", ErrCode, 3'd0);
        @(posedge C14M);
        #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [1:0]  b;
        logic [11:0] a;
        logic [1:0]  m;
        logic [15:0] d;
        logic [1:0]  oe;
        logic [15:0] dq;
        logic [15:0] dqcmp;
        logic        perr;
        logic [2:0]  ec;
        logic        rdy;
        logic [15:0] rc;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                                input logic [1:0] m, input logic [15:0] d, input logic [1:0] oe,
                                input logic [15:0] dq, input logic [15:0] dqcmp,
                                input logic perr, input logic [2:0] ec, input logic rdy,
                                input logic [15:0] rc);
        vec_t v;
        v.c = c; v.b = b; v.a = a; v.m = m; v.d = d; v.oe = oe; v.dq = dq;
        v.dqcmp = dqcmp; v.perr = perr; v.ec = ec; v.rdy = rdy; v.rc = rc;
        return v;
    endfunction

    vec_t tbl [$];
    logic [11:0] mrs_opts [4];

    initial begin
        RST = 1'b1; CKE = 1'b1; nCS = 1'b1; {nRAS, nCAS, nRWE} = NOP;
        BA = 2'd0; RA = 12'h000; DQML = 1'b1; DQMH = 1'b1; DQin = 16'h0000;
        mrs_opts[0] = 12'h220; mrs_opts[1] = 12'h230;
        mrs_opts[2] = 12'h200; mrs_opts[3] = 12'h221;

        // Init sequence, masked write, CL2 read, then idle-bank read and a later ACT error.
        tbl.push_back(mk(PRE, 2'd0, 12'h400, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 0, 16'd0));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(REF, 2'd0, 12'h000, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 0,
                             16'(i)));
        tbl.push_back(mk(MRS, 2'd0, 12'h220, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 1, 16'd16));
        tbl.push_back(mk(ACT, 2'd0, 12'h005, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 1, 16'd16));
        tbl.push_back(mk(WR, 2'd0, 12'h43C, 2'b10, 16'hA55A, 2'b00, 16'h0, 16'h0, 0, 0, 1,
                         16'd16));
        tbl.push_back(mk(ACT, 2'd0, 12'h005, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 1, 16'd16));
        tbl.push_back(mk(RD, 2'd0, 12'h43C, 2'b00, 16'h0, 2'b00, 16'h0, 16'h0, 0, 0, 1, 16'd16));
        tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 16'h0, 2'b11, 16'h005A, 16'h00FF, 0, 0, 1,
                         16'd16));
        tbl.push_back(mk(RD, 2'd0, 12'h03C, 2'b00, 16'h0, 2'b00, 16'h0, 16'h0, 1, 2, 1, 16'd16));
        tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 16'h0, 2'b00, 16'h0, 16'h0, 1, 2, 1, 16'd16));
        tbl.push_back(mk(ACT, 2'd1, 12'h003, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 1, 2, 1, 16'd16));
        tbl.push_back(mk(ACT, 2'd1, 12'h004, 2'b11, 16'h0, 2'b00, 16'h0, 16'h0, 1, 2, 1, 16'd16));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cmd(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].m, tbl[i].d);
            check($sformatf("vec%0d.DQOE", i), DQOE, tbl[i].oe);
            if (tbl[i].dqcmp != 16'h0)
                check($sformatf("vec%0d.DQout", i), DQout & tbl[i].dqcmp, tbl[i].dq & tbl[i].dqcmp);
            check($sformatf("vec%0d.ProtoErr", i), ProtoErr, tbl[i].perr);
            check($sformatf("vec%0d.ErrCode", i), ErrCode, tbl[i].ec);
            check($sformatf("vec%0d.Ready", i), Ready, tbl[i].rdy);
            check($sformatf("vec%0d.RefCount", i), RefCount, tbl[i].rc);
        end
        check("init.ModeReg", ModeReg, 12'h220);

        // CL3 timing and read-mask latency.
        do_reset();
        cmd(PRE, 2'd0, 12'h400, 2'b11, 16'h0);
        cmd(MRS, 2'd0, 12'h230, 2'b11, 16'h0);
        cmd(ACT, 2'd2, 12'h001, 2'b11, 16'h0);
        cmd(WR, 2'd2, 12'h007, 2'b00, 16'h1234);
        cmd(RD, 2'd2, 12'h007, 2'b00, 16'h0);
        cmd(NOP, 2'd0, 12'h000, 2'b10, 16'h0);
        check("cl3.n+1.DQOE", DQOE, 2'b00);
        cmd(NOP, 2'd0, 12'h000, 2'b00, 16'h0);
        check("cl3.n+2.DQOE", DQOE, 2'b01);
        check("cl3.n+2.DQout", DQout, 16'h1234);
        cmd(NOP, 2'd0, 12'h000, 2'b00, 16'h0);
        check("cl3.n+3.DQOE", DQOE, 2'b00);
        check("cl3.ProtoErr", ProtoErr, 1'b0);

        // REF with a bank open, then reset while a read is being driven.
        cmd(REF, 2'd0, 12'h000, 2'b11, 16'h0);
        check("ref.RefCount", RefCount, 16'd0);
        check("ref.ProtoErr", ProtoErr, 1'b1);
        check("ref.ErrCode", ErrCode, 3'd3);
        cmd(RD, 2'd2, 12'h007, 2'b00, 16'h0);
        cmd(NOP, 2'd0, 12'h000, 2'b00, 16'h0);
        cmd(NOP, 2'd0, 12'h000, 2'b00, 16'h0);
        check("midrd.DQOE.before", DQOE, 2'b11);
        do_reset();
        cmd(NOP, 2'd0, 12'h000, 2'b00, 16'h0);
        check("midrd.DQOE.after", DQOE, 2'b00);

        // Randomized traffic on a small address footprint.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            cmd(PRE, 2'd0, 12'h400, 2'b11, 16'h0);
            cmd(MRS, 2'd0, mrs_opts[seg], 2'b11, 16'h0);
            for (int i = 0; i < 500; i++) begin
                int r;
                logic [2:0]  c;
                logic [11:0] a;
                logic        cke, ncs;
                r = int'($urandom_range(0, 99));
                if (r < 15)      c = ACT;
                else if (r < 40) c = RD;
                else if (r < 65) c = WR;
                else if (r < 75) c = PRE;
                else if (r < 85) c = NOP;
                else if (r < 92) c = REF;
                else if (r < 97) c = MRS;
                else             c = BST;
                if (c == ACT) a = {8'($urandom), 2'b00, 2'($urandom)};
                else if (c == MRS) a = mrs_opts[$urandom_range(0, 3)];
                else a = {1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 5'b0,
                          3'($urandom)};
                if (c == MRS && p_data.size() != 0) c = NOP;
                cke = ($urandom_range(0, 19) != 0);
                ncs = ($urandom_range(0, 19) == 0);
                drive(c, 2'($urandom), a, 2'($urandom), 16'($urandom), cke, ncs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
